rvx_trace_capture_buffer: RTL and testbench

- Multi-channel triggered trace buffer. Generalises the single-channel fill-once capture log with: N channels, per-channel masking, a circular pre-trigger window, programmable post-trigger length, a sample timestamp counter, and an index-addressed registered read-back port.
- Sits beside a debug/monitor bus slave, which arms it, polls status and reads captured entries oldest-first.

---
 rtl/rvx_trace_capture_buffer.sv | 127 ++++++++++++
 tb/tb_rvx_trace_capture_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rvx_trace_capture_buffer.sv
// Multi-channel triggered trace buffer: circular pre-trigger window, programmable
// post-trigger length, sample timestamp and a registered oldest-first read port.
module rvx_trace_capture_buffer #(
  parameter int WIDTH        = 8,
  parameter int NUM_CHANNEL  = 2,
  parameter int DEPTH        = 16,
  parameter int BW_TIMESTAMP = 16,
  localparam int BW_INDEX    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         sample_valid,
  input  logic [NUM_CHANNEL*WIDTH-1:0] sample_data,
  input  logic [NUM_CHANNEL-1:0]       channel_mask,
  input  logic                         trigger,
  input  logic [BW_INDEX-1:0]          pre_trigger_num,
  output logic [1:0]                   state,
  output logic                         is_done,
  output logic [BW_INDEX:0]            entry_count,
  output logic [BW_INDEX-1:0]          trigger_index,
  output logic                         overflow,
  output logic [BW_TIMESTAMP-1:0]      sample_total,
  input  logic [BW_INDEX-1:0]          rindex,
  output logic [NUM_CHANNEL*WIDTH-1:0] rdata
);

  localparam int DW = NUM_CHANNEL * WIDTH;
  localparam int AW = BW_INDEX + 2;
  localparam logic [BW_INDEX:0]   DEPTH_C = (BW_INDEX + 1)'(DEPTH);
  localparam logic [BW_INDEX-1:0] LAST_C  = BW_INDEX'(DEPTH - 1);
  localparam logic [AW-1:0]       DEPTH_W = AW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t              st;
  logic [DW-1:0]       mem [DEPTH];
  logic [BW_INDEX-1:0] wptr;
  logic [BW_INDEX-1:0] p_lat;
  logic [BW_INDEX-1:0] post_left;
  logic [DW-1:0]       wdata;
  logic [DW-1:0]       rd_value;
  logic [AW-1:0]       oldest_w;
  logic [AW-1:0]       addr_w;
  logic [BW_INDEX-1:0] rd_addr;
  logic                accept;

  assign state   = st;
  assign is_done = (st == DONE);
  assign accept  = sample_valid && !abort && ((st == ARMED) || (st == POST));

  always_comb begin
    wdata = '0;
    for (int c = 0; c < NUM_CHANNEL; c++)
      if (channel_mask[c]) wdata[c*WIDTH +: WIDTH] = sample_data[c*WIDTH +: WIDTH];
  end

  // Logical index -> physical slot, oldest entry sits entry_count slots behind wptr.
  always_comb begin
    oldest_w = AW'(wptr) + DEPTH_W - AW'(entry_count);
    if (oldest_w >= DEPTH_W) oldest_w = oldest_w - DEPTH_W;
    addr_w = oldest_w + AW'(rindex);
    if (addr_w >= DEPTH_W) addr_w = addr_w - DEPTH_W;
    rd_addr  = addr_w[BW_INDEX-1:0];
    rd_value = ({1'b0, rindex} >= entry_count) ? '0 : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      wptr          <= '0;
      entry_count   <= '0;
      trigger_index <= '0;
      overflow      <= 1'b0;
      sample_total  <= '0;
      p_lat         <= '0;
      post_left     <= '0;
      rdata         <= '0;
    end else begin
      rdata <= rd_value;
      if (accept) begin
        wptr         <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
        sample_total <= sample_total + 1'b1;
        if (entry_count == DEPTH_C) overflow <= 1'b1;
        else entry_count <= entry_count + 1'b1;
      end
      if (abort) begin
        st <= IDLE;
      end else begin
        case (st)
          IDLE, DONE: begin
            if (arm) begin
              st            <= ARMED;
              wptr          <= '0;
              entry_count   <= '0;
              overflow      <= 1'b0;
              sample_total  <= '0;
              trigger_index <= '0;
              p_lat         <= pre_trigger_num;
            end
          end
          ARMED: begin
            if (sample_valid && trigger) begin
              // entry_count saturates at DEPTH > P, so min(entry_count, P) == min(K, P)
              trigger_index <= (entry_count >= {1'b0, p_lat}) ? p_lat : entry_count[BW_INDEX-1:0];
              post_left     <= LAST_C - p_lat;
              st            <= (p_lat == LAST_C) ? DONE : POST;
            end
          end
          POST: begin
            if (sample_valid) begin
              post_left <= post_left - 1'b1;
              if (post_left == BW_INDEX'(1)) st <= DONE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rvx_trace_capture_buffer.sv
// Directed bench for rvx_trace_capture_buffer with hand-computed expectations.
module tb_rvx_trace_capture_buffer;

  logic        clk = 1'b0;
  logic        rst, arm, abort, sample_valid, trigger;
  logic [15:0] sample_data;
  logic [1:0]  channel_mask;
  logic [3:0]  pre_trigger_num, rindex, trigger_index;
  logic [1:0]  state;
  logic        is_done, overflow;
  logic [4:0]  entry_count;
  logic [15:0] sample_total, rdata;

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvx_trace_capture_buffer dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .sample_valid(sample_valid),
    .sample_data(sample_data), .channel_mask(channel_mask), .trigger(trigger),
    .pre_trigger_num(pre_trigger_num), .state(state), .is_done(is_done),
    .entry_count(entry_count), .trigger_index(trigger_index), .overflow(overflow),
    .sample_total(sample_total), .rindex(rindex), .rdata(rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] v);
    return {v ^ 8'h5A, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic trg);
    sample_valid = 1'b1;
    sample_data  = d;
    trigger      = trg;
    tick();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] p);
    pre_trigger_num = p;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, output logic [15:0] val);
    rindex = idx;
    tick();
    val = rdata;
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    sample_data = '0; channel_mask = 2'b11; pre_trigger_num = '0; rindex = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_count", entry_count, 0);
    check("rst_rdata", rdata, 0);
    check("rst_done", is_done, 0);

    // Window fully pre-filled: P=4, trigger on sample 0x06, last sample 0x11
    do_arm(4'd4);
    check("t1_armed", state, 1);
    for (int i = 0; i < 6; i++) send(mk(8'(i)), 1'b0);
    send(mk(8'h06), 1'b1);
    check("t1_post", state, 2);
    for (int i = 7; i < 17; i++) send(mk(8'(i)), 1'b0);
    check("t1_still_post", state, 2);
    send(mk(8'h11), 1'b0);
    check("t1_done", state, 3);
    check("t1_is_done", is_done, 1);
    check("t1_count", entry_count, 16);
    check("t1_tidx", trigger_index, 4);
    check("t1_total", sample_total, 18);
    for (int i = 2; i < 18; i++) exp_q.push_back(mk(8'(i)));
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      check("t1_read", v, exp_q.pop_front());
    end

    // Early trigger: K=1 < P=4
    do_arm(4'd4);
    send(mk(8'hA0), 1'b0);
    send(mk(8'hA1), 1'b1);
    for (int i = 2; i < 13; i++) send(mk(8'(8'hA0 + i)), 1'b0);
    check("t2_done", state, 3);
    check("t2_count", entry_count, 13);
    check("t2_tidx", trigger_index, 1);
    rd(4'd0, v);  check("t2_read0", v, mk(8'hA0));
    rd(4'd1, v);  check("t2_read1", v, mk(8'hA1));
    rd(4'd12, v); check("t2_read12", v, mk(8'hAC));
    rd(4'd13, v); check("t2_read13", v, 0);

    // P=15: zero post-trigger length, trigger on 20th sample
    do_arm(4'd15);
    for (int i = 0; i < 19; i++) send(mk(8'(8'h30 + i)), 1'b0);
    check("t3_armed", state, 1);
    send(mk(8'h43), 1'b1);
    check("t3_done", state, 3);
    check("t3_count", entry_count, 16);
    check("t3_tidx", trigger_index, 15);
    check("t3_ovf", overflow, 1);
    check("t3_total", sample_total, 20);
    rd(4'd15, v); check("t3_read15", v, mk(8'h43));

    // Channel mask and unqualified trigger
    do_arm(4'd4);
    check("t4_ovf_clr", overflow, 0);
    channel_mask = 2'b01;
    send(16'hBBAA, 1'b0);
    channel_mask = 2'b11;
    trigger = 1'b1; tick(); trigger = 1'b0;
    check("t4_armed", state, 1);
    rd(4'd0, v); check("t4_mask", v, 16'h00AA);

    // Mid-POST abort holds results, no further writes
    abort = 1'b1; tick(); abort = 1'b0;
    do_arm(4'd2);
    send(mk(8'hB0), 1'b0);
    send(mk(8'hB1), 1'b0);
    send(mk(8'hB2), 1'b1);
    send(mk(8'hB3), 1'b0);
    send(mk(8'hB4), 1'b0);
    check("t5_post", state, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_idle", state, 0);
    send(mk(8'hB5), 1'b0);
    check("t5_count", entry_count, 5);
    check("t5_tidx", trigger_index, 2);
    check("t5_total", sample_total, 5);
    rd(4'd4, v); check("t5_read4", v, mk(8'hB4));
    rd(4'd5, v); check("t5_read5", v, 0);

    // arm+abort in DONE -> IDLE
    do_arm(4'd15);
    send(mk(8'hC0), 1'b1);
    check("t5_done", state, 3);
    check("t5_done_count", entry_count, 1);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    check("t5_arm_abort", state, 0);

    // Mid-POST reset, then a normal capture
    do_arm(4'd4);
    send(mk(8'hD0), 1'b1);
    send(mk(8'hD1), 1'b0);
    rindex = 4'd0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_state", state, 0);
    check("t6_count", entry_count, 0);
    check("t6_tidx", trigger_index, 0);
    check("t6_ovf", overflow, 0);
    check("t6_total", sample_total, 0);
    check("t6_rdata", rdata, 0);
    check("t6_done", is_done, 0);
    do_arm(4'd4);
    pre_trigger_num = 4'd0;
    for (int i = 0; i < 3; i++) send(mk(8'(8'hE0 + i)), 1'b0);
    send(mk(8'hE3), 1'b1);
    for (int i = 4; i < 15; i++) send(mk(8'(8'hE0 + i)), 1'b0);
    check("t6_cap_done", state, 3);
    check("t6_cap_count", entry_count, 15);
    check("t6_cap_tidx", trigger_index, 3);
    rd(4'd3, v); check("t6_read3", v, mk(8'hE3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
